// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD widths, counter FSM state type and digit check
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one loadable BCD digit decrementing on borrow-in
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [BCD_W-1:0] d,
  input  logic             bin,
  output logic [BCD_W-1:0] q,
  output logic             bout
);
  assign bout = bin & (q == '0);
  // load wins over decrement; 0 wraps to 9 and borrows from the next digit
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (ld) q <= d;
    else if (bin) q <= (q == '0) ? BCD_MAX : q - 1'b1;
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: loadable multi-digit BCD countdown with borrow pulse (option: BCD_DOWN_AUTORELOAD_EN)
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] din,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    dec,
  output logic [BCD_W*DIGITS-1:0] q,
  output logic                    bout,
  output logic                    zero,
  output logic                    busy,
  output logic                    err
);
  localparam int W = BCD_W * DIGITS;
  state_t st;
  logic din_ok, acc, cnt, term, rl, ld;
  logic [W-1:0] ld_val;
  logic [DIGITS:0] b;
  // a preset is accepted only if every digit is a legal BCD value
  always_comb begin
    din_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) din_ok = din_ok & bcd_valid(din[BCD_W*i +: BCD_W]);
  end
  assign acc  = load & din_ok;
  assign cnt  = ~load & ~pause & dec & (st == RUN);
  assign term = cnt & (q == W'(1));
`ifdef BCD_DOWN_AUTORELOAD_EN
  logic [W-1:0] rld;
  // reload register captures every accepted preset
  always_ff @(posedge clk or posedge rst)
    if (rst) rld <= '0;
    else if (acc) rld <= din;
  assign rl     = term & (rld != '0);
  assign ld_val = acc ? din : rl ? rld : '0;
`else
  assign rl     = 1'b0;
  assign ld_val = acc ? din : '0;
`endif
  // a borrow out of the top digit would be an underflow; it forces a clear instead
  assign ld   = acc | rl | b[DIGITS];
  assign b[0] = cnt;
  for (genvar j = 0; j < DIGITS; j++) begin : g_dig
    bcd_down_digit u_dig (
      .clk (clk),
      .rst (rst),
      .ld  (ld),
      .d   (ld_val[BCD_W*j +: BCD_W]),
      .bin (b[j]),
      .q   (q[BCD_W*j +: BCD_W]),
      .bout(b[j+1])
    );
  end
  assign zero = (q == '0);
  assign busy = (st == RUN) | (st == PAUSE);
  // state and one-cycle pulses; load outranks pause, start and dec
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st   <= IDLE;
      bout <= 1'b0;
      err  <= 1'b0;
    end else begin
      err  <= load & ~din_ok;
      bout <= term;
      st   <= acc ? IDLE
            : load ? st
            : (st == RUN) ? (pause ? PAUSE : (term & ~rl) ? DONE : RUN)
            : (st == PAUSE) ? (pause ? PAUSE : RUN)
            : (st == IDLE && start) ? (zero ? DONE : RUN)
            : st;
    end
endmodule
